// File: rtl/open_drain_output_pad_ctrl_pkg.sv
// Shared definitions for the open-drain pad controller: state encodings and
// parameter-legality helpers evaluated at elaboration.
package open_drain_output_pad_ctrl_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    DRIVE_LOW = 2'd1,
    WAIT_RISE = 2'd2,
    STUCK     = 2'd3
  } od_state_t;

  function automatic bit sync_stages_ok(input int sync_stages);
    return (sync_stages >= 2) && (sync_stages <= 4);
  endfunction

  // The synchroniser delay is spent inside the rise window, so the window
  // must be longer than the synchroniser.
  function automatic bit rise_timeout_ok(input int rise_timeout, input int sync_stages);
    return rise_timeout >= (sync_stages + 1);
  endfunction

  function automatic bit cnt_w_ok(input int cnt_w, input int rise_timeout);
    return (cnt_w >= 1) && (cnt_w <= 31) && ((64'd1 << cnt_w) > 64'(rise_timeout));
  endfunction

endpackage

// File: rtl/pad_input_sync.sv
// Multi-flop synchroniser for an asynchronous pad readback; SYNC_STAGES cycles
// of latency, no backpressure, reset loads every stage with RESET_VAL.
module pad_input_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/open_drain_output_pad_ctrl.sv
// Registered open-drain driver: one cycle request-to-pad, times the pullup rise
// after release and flags stuck or externally-held-low lines.
module open_drain_output_pad_ctrl
  import open_drain_output_pad_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int RISE_TIMEOUT = 16,
  parameter int CNT_W        = 8
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic OE_EN,
  input  logic DOUT,
  input  logic CLR_STUCK,
  input  logic PAD_IN,
  output logic PAD_OEN,
  output logic DIN_SYNC,
  output logic BUSY,
  output logic EXT_LOW,
  output logic STUCK_LOW
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be in 2..4");
  end
  if (!rise_timeout_ok(RISE_TIMEOUT, SYNC_STAGES)) begin : g_bad_rise_timeout
    $error("RISE_TIMEOUT must be >= SYNC_STAGES+1");
  end
  if (!cnt_w_ok(CNT_W, RISE_TIMEOUT)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for RISE_TIMEOUT");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RISE_TIMEOUT - 1);

  od_state_t        state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             stuck_set;
  logic             drv_req;
  logic             pad_oen_q;
  logic             stuck_low_q;
  logic             din_sync;

  assign drv_req = OE_EN & ~DOUT;

  pad_input_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_sync (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .async_in(PAD_IN),
    .sync_out(din_sync)
  );

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    stuck_set  = 1'b0;
    unique case (state)
      RELEASED: begin
        if (drv_req) next_state = DRIVE_LOW;
      end
      DRIVE_LOW: begin
        if (!drv_req) begin
          next_state = WAIT_RISE;
          next_cnt   = '0;
        end
      end
      WAIT_RISE: begin
        if (drv_req) begin
          next_state = DRIVE_LOW;
        end else if (din_sync) begin
          next_state = RELEASED;
        end else if (cnt == CNT_LAST) begin
          next_state = STUCK;
          stuck_set  = 1'b1;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      STUCK: begin
        if (drv_req) begin
          next_state = DRIVE_LOW;
        end else if (din_sync) begin
          next_state = RELEASED;
        end
      end
      default: next_state = RELEASED;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state       <= RELEASED;
      cnt         <= '0;
      pad_oen_q   <= 1'b1;
      stuck_low_q <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      pad_oen_q <= ~(next_state == DRIVE_LOW);
      // A fresh timeout outranks a coincident clear.
      if (stuck_set) begin
        stuck_low_q <= 1'b1;
      end else if (CLR_STUCK) begin
        stuck_low_q <= 1'b0;
      end
    end
  end

  assign PAD_OEN   = pad_oen_q;
  assign DIN_SYNC  = din_sync;
  assign BUSY      = (state == WAIT_RISE);
  assign EXT_LOW   = (state == RELEASED) & ~din_sync;
  assign STUCK_LOW = stuck_low_q;

endmodule

// File: tb/tb_open_drain_output_pad_ctrl.sv
// Bench for open_drain_output_pad_ctrl: vector table, corner sequences and a
// randomized run against an elapsed-time reference model.
module tb_open_drain_output_pad_ctrl;

  localparam int SYNC = 2;
  localparam int TMO  = 16;

  logic HCLK = 1'b0;
  logic HRESETn, OE_EN, DOUT, CLR_STUCK, PAD_IN;
  logic PAD_OEN, DIN_SYNC, BUSY, EXT_LOW, STUCK_LOW;

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  open_drain_output_pad_ctrl #(
    .SYNC_STAGES (SYNC),
    .RISE_TIMEOUT(TMO),
    .CNT_W       (8)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .OE_EN    (OE_EN),
    .DOUT     (DOUT),
    .CLR_STUCK(CLR_STUCK),
    .PAD_IN   (PAD_IN),
    .PAD_OEN  (PAD_OEN),
    .DIN_SYNC (DIN_SYNC),
    .BUSY     (BUSY),
    .EXT_LOW  (EXT_LOW),
    .STUCK_LOW(STUCK_LOW)
  );

  // Reference model: pad is driven, or released and waiting for a rise with an
  // elapsed-cycle timer, or released after a timeout; readback is a delay line.
  bit   m_drv, m_wait, m_timed_out, m_flag;
  int   m_elapsed;
  logic m_hist [SYNC];

  task automatic model_edge(input logic r, input logic oe, input logic dout,
                            input logic clr, input logic pad);
    logic seen, req, set;
    seen = m_hist[SYNC-1];
    req  = oe & ~dout;
    set  = 1'b0;
    if (!r) begin
      m_drv = 0; m_wait = 0; m_timed_out = 0; m_flag = 0; m_elapsed = 0;
      for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b1;
    end else begin
      if (req) begin
        m_drv = 1; m_wait = 0; m_timed_out = 0;
      end else if (m_drv) begin
        m_drv = 0; m_wait = 1; m_elapsed = 0;
      end else if (m_wait) begin
        if (seen) m_wait = 0;
        else if (m_elapsed + 1 == TMO) begin
          m_wait = 0; m_timed_out = 1; set = 1'b1;
        end else m_elapsed++;
      end else if (m_timed_out && seen) begin
        m_timed_out = 0;
      end
      if (set) m_flag = 1;
      else if (clr) m_flag = 0;
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pad;
    end
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", nm, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic oe, input logic dout,
                      input logic clr, input logic pad);
    HRESETn = r; OE_EN = oe; DOUT = dout; CLR_STUCK = clr; PAD_IN = pad;
    @(posedge HCLK);
    model_edge(r, oe, dout, clr, pad);
    #1;
    chk("model_pad_oen", PAD_OEN, !m_drv);
    chk("model_din_sync", DIN_SYNC, m_hist[SYNC-1]);
    chk("model_busy", BUSY, m_wait);
    chk("model_ext_low", EXT_LOW, !m_drv && !m_wait && !m_timed_out && !m_hist[SYNC-1]);
    chk("model_stuck_low", STUCK_LOW, m_flag);
  endtask

  typedef struct {
    logic rst_n, oe, dout, clr, pad;
    logic oen, din, busy, ext, stk;
  } vec_t;

  localparam int NV = 25;
  vec_t tv [NV];

  function automatic vec_t mk(input logic [4:0] in, input logic [4:0] ex);
    vec_t v;
    {v.rst_n, v.oe, v.dout, v.clr, v.pad} = in;
    {v.oen, v.din, v.busy, v.ext, v.stk}  = ex;
    return v;
  endfunction

  // Drive the pad for three cycles with the line low, then release it.
  task automatic drive_low_then_release();
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("release_busy", BUSY, 1'b1);
    chk("release_oen", PAD_OEN, 1'b1);
  endtask

  initial begin
    int low_left;
    logic oe, dout, clr, rst, pad;

    //            rst oe dout clr pad     oen din busy ext stk
    tv[0]  = mk(5'b0_0_1_0_1, 5'b1_1_0_0_0);
    tv[1]  = mk(5'b1_0_1_0_1, 5'b1_1_0_0_0);
    tv[2]  = mk(5'b1_0_1_0_1, 5'b1_1_0_0_0);
    tv[3]  = mk(5'b1_1_0_0_1, 5'b0_1_0_0_0);
    tv[4]  = mk(5'b1_1_0_0_0, 5'b0_1_0_0_0);
    tv[5]  = mk(5'b1_1_0_0_0, 5'b0_0_0_0_0);
    tv[6]  = mk(5'b1_1_1_0_0, 5'b1_0_1_0_0);
    tv[7]  = mk(5'b1_1_1_0_0, 5'b1_0_1_0_0);
    tv[8]  = mk(5'b1_1_1_0_0, 5'b1_0_1_0_0);
    tv[9]  = mk(5'b1_1_1_0_1, 5'b1_0_1_0_0);
    tv[10] = mk(5'b1_1_1_0_1, 5'b1_1_1_0_0);
    tv[11] = mk(5'b1_1_1_0_1, 5'b1_1_0_0_0);
    tv[12] = mk(5'b1_0_1_0_0, 5'b1_1_0_0_0);
    tv[13] = mk(5'b1_0_1_0_0, 5'b1_0_0_1_0);
    tv[14] = mk(5'b1_0_1_0_0, 5'b1_0_0_1_0);
    tv[15] = mk(5'b1_0_1_0_0, 5'b1_0_0_1_0);
    tv[16] = mk(5'b1_0_1_0_0, 5'b1_0_0_1_0);
    tv[17] = mk(5'b1_0_1_0_1, 5'b1_0_0_1_0);
    tv[18] = mk(5'b1_0_1_0_1, 5'b1_1_0_0_0);
    tv[19] = mk(5'b1_0_0_0_1, 5'b1_1_0_0_0);
    tv[20] = mk(5'b1_0_0_0_1, 5'b1_1_0_0_0);
    tv[21] = mk(5'b1_1_0_0_1, 5'b0_1_0_0_0);
    tv[22] = mk(5'b1_1_0_0_0, 5'b0_1_0_0_0);
    tv[23] = mk(5'b0_1_0_0_0, 5'b1_1_0_0_0);
    tv[24] = mk(5'b1_0_1_0_1, 5'b1_1_0_0_0);

    HRESETn = 0; OE_EN = 0; DOUT = 1; CLR_STUCK = 0; PAD_IN = 1;
    m_drv = 0; m_wait = 0; m_timed_out = 0; m_flag = 0; m_elapsed = 0;
    for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b1;
    repeat (2) @(posedge HCLK);

    for (int i = 0; i < NV; i++) begin
      step(tv[i].rst_n, tv[i].oe, tv[i].dout, tv[i].clr, tv[i].pad);
      chk("tbl_pad_oen", PAD_OEN, tv[i].oen);
      chk("tbl_din_sync", DIN_SYNC, tv[i].din);
      chk("tbl_busy", BUSY, tv[i].busy);
      chk("tbl_ext_low", EXT_LOW, tv[i].ext);
      chk("tbl_stuck_low", STUCK_LOW, tv[i].stk);
    end

    // Stuck line: BUSY for exactly TMO cycles, then sticky flag.
    drive_low_then_release();
    for (int i = 1; i < TMO; i++) begin
      step(1, 1, 1, 0, 0);
      chk("stuck_busy_window", BUSY, 1'b1);
      chk("stuck_not_yet", STUCK_LOW, 1'b0);
    end
    step(1, 1, 1, 0, 0);
    chk("timeout_busy", BUSY, 1'b0);
    chk("timeout_flag", STUCK_LOW, 1'b1);
    repeat (3) step(1, 1, 1, 0, 1);
    chk("recover_flag_held", STUCK_LOW, 1'b1);
    chk("recover_ext_low", EXT_LOW, 1'b0);
    step(1, 1, 1, 1, 1);
    chk("clr_pulse", STUCK_LOW, 1'b0);
    step(1, 1, 1, 0, 1);
    chk("clr_stays", STUCK_LOW, 1'b0);

    // Clear on the timeout edge loses to the set; a clear while still stuck wins.
    drive_low_then_release();
    for (int i = 1; i < TMO; i++) step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    chk("clr_vs_set", STUCK_LOW, 1'b1);
    step(1, 1, 1, 0, 0);
    chk("set_sticky", STUCK_LOW, 1'b1);
    step(1, 1, 1, 1, 0);
    chk("clr_in_stuck", STUCK_LOW, 1'b0);
    repeat (3) step(1, 1, 1, 0, 0);
    chk("no_reset_in_stuck", STUCK_LOW, 1'b0);
    chk("stuck_not_busy", BUSY, 1'b0);
    repeat (3) step(1, 1, 1, 0, 1);
    chk("back_released", EXT_LOW, 1'b0);

    // Randomized run: the line follows the driver, with occasional external
    // holds and slow rises.
    low_left = 0;
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 299) != 0);
      oe   = ($urandom_range(0, 7) != 0);
      dout = ($urandom_range(0, 5) == 0) ? ~DOUT : DOUT;
      clr  = ($urandom_range(0, 19) == 0);
      if (low_left > 0) low_left--;
      else if ($urandom_range(0, 14) == 0) low_left = $urandom_range(1, 25);
      pad = m_drv ? 1'b0 : (low_left > 0 ? 1'b0 : 1'b1);
      step(rst, oe, dout, clr, pad);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
